// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-controller signal bundle between pipeline and controller
//
// Purpose: groups every hazard input and stage-control output of
// pipe_hazard_ctrl so the pipeline top connects it with a single port.
//   master : pipeline side (drives hazard inputs, consumes controls)
//   slave  : controller side (consumes hazard inputs, drives controls)
// Signals:
//   ifu_rdy_i, lsu_busy_i, ex_busy_i            stall sources
//   id_rs1_i/id_rs2_i, id_rs*_used_i            ID source operands
//   ex_rd_i, ex_wen_i, ex_is_load_i             EX destination info
//   ex_redirect_i/_pc_i, trap_i/trap_pc_i       redirect sources
//   *_stall_n_o, *_flush_o                      stage-register controls
//   pc_redirect_o/pc_redirect_addr_o            PC redirect
//   lsu_kill_o, state_o                         LSU abort, RUN/DRAIN
//   redirect_q_o                                last issued redirect target (debug)

interface pipe_hazard_ctrl_if #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
);
   logic              ifu_rdy_i;
   logic              lsu_busy_i;
   logic              ex_busy_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic              id_rs1_used_i;
   logic              id_rs2_used_i;
   logic [REG_AW-1:0] ex_rd_i;
   logic              ex_wen_i;
   logic              ex_is_load_i;
   logic              ex_redirect_i;
   logic [XLEN-1:0]   ex_redirect_pc_i;
   logic              trap_i;
   logic [XLEN-1:0]   trap_pc_i;

   logic              pc_stall_n_o;
   logic              if_id_stall_n_o;
   logic              id_ex_stall_n_o;
   logic              ex_mem_stall_n_o;
   logic              mem_wb_stall_n_o;
   logic              if_id_flush_o;
   logic              id_ex_flush_o;
   logic              ex_mem_flush_o;
   logic              mem_wb_flush_o;
   logic              pc_redirect_o;
   logic [XLEN-1:0]   pc_redirect_addr_o;
   logic              lsu_kill_o;
   logic              state_o;
   logic [XLEN-1:0]   redirect_q_o;

   modport master (
      output ifu_rdy_i, lsu_busy_i, ex_busy_i,
             id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
             ex_rd_i, ex_wen_i, ex_is_load_i,
             ex_redirect_i, ex_redirect_pc_i, trap_i, trap_pc_i,
      input  pc_stall_n_o, if_id_stall_n_o, id_ex_stall_n_o,
             ex_mem_stall_n_o, mem_wb_stall_n_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
             pc_redirect_o, pc_redirect_addr_o, lsu_kill_o, state_o,
             redirect_q_o
   );

   modport slave (
      input  ifu_rdy_i, lsu_busy_i, ex_busy_i,
             id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
             ex_rd_i, ex_wen_i, ex_is_load_i,
             ex_redirect_i, ex_redirect_pc_i, trap_i, trap_pc_i,
      output pc_stall_n_o, if_id_stall_n_o, id_ex_stall_n_o,
             ex_mem_stall_n_o, mem_wb_stall_n_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
             pc_redirect_o, pc_redirect_addr_o, lsu_kill_o, state_o,
             redirect_q_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/redirect controller for the 5-stage in-order pipeline
//
// Purpose: resolves trap, data-memory wait, multi-cycle EX, EX redirect,
// load-use and fetch-latency hazards into per-stage stall_n/flush controls
// and a PC redirect. A RUN/DRAIN FSM discards the stale fetch that is still
// in flight when a redirect fires before the fetch returned.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_hazard_ctrl_if.slave (hazard inputs, stage controls, state)
// Optional (macro PIPE_CTRL_PERF_EN):
//   perf_stall_cnt_o : cycles with the PC stalled (wraps)
//   perf_flush_cnt_o : cycles with a PC redirect issued (wraps)

module pipe_hazard_ctrl #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_hazard_ctrl_if.slave   bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]         perf_stall_cnt_o,
   output logic [31:0]         perf_flush_cnt_o
`endif
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_redirect_q;

   logic              w_pc_sn, w_if_id_sn, w_id_ex_sn, w_ex_mem_sn, w_mem_wb_sn;
   logic              w_if_id_fl, w_id_ex_fl, w_ex_mem_fl, w_mem_wb_fl;
   logic              w_redirect;
   logic [XLEN-1:0]   w_redirect_addr;
   logic              w_kill;
   logic              w_load_use;

   // Bypass cannot cover a load result needed by the very next instruction.
   assign w_load_use = bus.ex_is_load_i & bus.ex_wen_i &
                       (bus.ex_rd_i != '0) &
                       ((bus.id_rs1_used_i & (bus.id_rs1_i == bus.ex_rd_i)) |
                        (bus.id_rs2_used_i & (bus.id_rs2_i == bus.ex_rd_i)));

   always_comb begin
      w_pc_sn         = 1'b1;
      w_if_id_sn      = 1'b1;
      w_id_ex_sn      = 1'b1;
      w_ex_mem_sn     = 1'b1;
      w_mem_wb_sn     = 1'b1;
      w_if_id_fl      = 1'b0;
      w_id_ex_fl      = 1'b0;
      w_ex_mem_fl     = 1'b0;
      w_mem_wb_fl     = 1'b0;
      w_redirect      = 1'b0;
      w_redirect_addr = '0;
      w_kill          = 1'b0;

      if (!rst_n) begin
         // Every stage register loads a bubble while reset is held.
         w_if_id_fl  = 1'b1;
         w_id_ex_fl  = 1'b1;
         w_ex_mem_fl = 1'b1;
         w_mem_wb_fl = 1'b1;
      end else if (bus.trap_i) begin
         w_redirect      = 1'b1;
         w_redirect_addr = bus.trap_pc_i;
         w_if_id_fl      = 1'b1;
         w_id_ex_fl      = 1'b1;
         w_ex_mem_fl     = 1'b1;
         w_mem_wb_fl     = 1'b1;
         w_kill          = bus.lsu_busy_i;
      end else if (bus.lsu_busy_i) begin
         // Freeze everything upstream of MEM; a pending EX redirect stays
         // held in EX and reasserts once the freeze lifts.
         w_pc_sn     = 1'b0;
         w_if_id_sn  = 1'b0;
         w_id_ex_sn  = 1'b0;
         w_ex_mem_sn = 1'b0;
         w_mem_wb_fl = 1'b1;
      end else if (bus.ex_busy_i) begin
         w_pc_sn     = 1'b0;
         w_if_id_sn  = 1'b0;
         w_id_ex_sn  = 1'b0;
         w_ex_mem_fl = 1'b1;
      end else if (r_state == ST_DRAIN) begin
         // Stale fetch still outstanding: hold the redirected PC and keep
         // IF/ID empty; ID and EX only ever see bubbles here.
         w_pc_sn    = 1'b0;
         w_if_id_fl = 1'b1;
      end else if (bus.ex_redirect_i) begin
         w_redirect      = 1'b1;
         w_redirect_addr = bus.ex_redirect_pc_i;
         w_if_id_fl      = 1'b1;
         w_id_ex_fl      = 1'b1;
      end else if (w_load_use) begin
         w_pc_sn    = 1'b0;
         w_if_id_sn = 1'b0;
         w_id_ex_fl = 1'b1;
      end else if (!bus.ifu_rdy_i) begin
         w_pc_sn    = 1'b0;
         w_if_id_fl = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_redirect_q <= '0;
      end else begin
         if (w_redirect) begin
            r_redirect_q <= w_redirect_addr;
         end
         case (r_state)
            ST_RUN: begin
               if (w_redirect && !bus.ifu_rdy_i) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // A trap here starts a new fetch, so the drain continues.
               if (!bus.trap_i && bus.ifu_rdy_i) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign bus.pc_stall_n_o       = w_pc_sn;
   assign bus.if_id_stall_n_o    = w_if_id_sn;
   assign bus.id_ex_stall_n_o    = w_id_ex_sn;
   assign bus.ex_mem_stall_n_o   = w_ex_mem_sn;
   assign bus.mem_wb_stall_n_o   = w_mem_wb_sn;
   assign bus.if_id_flush_o      = w_if_id_fl;
   assign bus.id_ex_flush_o      = w_id_ex_fl;
   assign bus.ex_mem_flush_o     = w_ex_mem_fl;
   assign bus.mem_wb_flush_o     = w_mem_wb_fl;
   assign bus.pc_redirect_o      = w_redirect;
   assign bus.pc_redirect_addr_o = w_redirect_addr;
   assign bus.lsu_kill_o         = w_kill;
   assign bus.state_o            = r_state;
   assign bus.redirect_q_o       = r_redirect_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall_cnt <= '0;
         r_perf_flush_cnt <= '0;
      end else begin
         if (!w_pc_sn) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
         if (w_redirect) begin
            r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
         end
      end
   end

   assign perf_stall_cnt_o = r_perf_stall_cnt;
   assign perf_flush_cnt_o = r_perf_flush_cnt;
`endif

endmodule
